fetch_pc_gen: RTL and testbench

Instruction-fetch front end that sits directly upstream of decode. It owns the fetch PC and issues in-order requests to instruction memory. Each returned word goes through a static backward-taken/forward-not-taken (BTFN) prediction using the team's B-type target decoder, and the annotated instruction is buffered in a small queue that feeds decode over a valid/ready handshake. The backend overrides the fetch PC on a mispredict or exception through a redirect port.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/bp_se.sv | 17 +
 rtl/fetch_queue.sv | 57 +++++
 rtl/fetch_pc_gen.sv | 127 ++++++++++++
 tb/tb_fetch_pc_gen.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
    } fetch_entry_t;

endpackage

// File: rtl/bp_se.sv
// B-type branch decoder: flags conditional branches and forms pc + sign-extended imm_b.
module bp_se
    import fetch_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output logic        is_branch,
    output logic [31:0] target
);

    logic [31:0] imm_b;

    assign is_branch = (instr[6:0] == OPC_BRANCH);
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign target    = pc + imm_b;

endmodule

// File: rtl/fetch_queue.sv
// Generic DEPTH-entry FIFO with synchronous flush; push while full is allowed when popping.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so the head reads zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: credit-limited imem requests, BTFN prediction, and a decode-side queue.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        dec_pred_taken,
    output logic [31:0] dec_pred_target
);

    localparam int            CW  = $clog2(DEPTH + 1);
    localparam logic [CW:0]   CAP = (CW + 1)'(DEPTH);

    logic [31:0]  fetch_pc;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] q_count;
    logic [CW-1:0] out_next;
    logic [CW:0]   credit_sum;
    logic         running;
    logic         req_fire;
    logic [31:0]  resp_pc;
    logic         is_branch;
    logic [31:0]  br_target;
    logic         pred_taken;
    logic         resp_keep;
    logic         take;
    logic         dec_fire;
    fetch_entry_t entry;
    fetch_entry_t q_head;

    // Every in-flight request plus every queued word must fit in the queue.
    assign credit_sum     = {1'b0, out_cnt} + {1'b0, q_count};
    assign imem_req_valid = running && (credit_sum < CAP) && !redir_valid;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // The address FIFO occupancy is the outstanding-request count.
    fetch_queue #(.WIDTH(32), .DEPTH(DEPTH)) u_req_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (req_fire),
        .push_data (fetch_pc),
        .pop       (imem_resp_valid),
        .head      (resp_pc),
        .count     (out_cnt)
    );

    bp_se u_bp_se (
        .instr     (imem_resp_data),
        .pc        (resp_pc),
        .is_branch (is_branch),
        .target    (br_target)
    );

    assign pred_taken = is_branch && imem_resp_data[31];
    assign resp_keep  = imem_resp_valid && (drop_cnt == '0) && !redir_valid;
    assign take       = resp_keep && pred_taken;
    assign out_next   = out_cnt + CW'(req_fire) - CW'(imem_resp_valid);

    always_comb begin
        entry.instr       = imem_resp_data;
        entry.pc          = resp_pc;
        entry.pred_taken  = pred_taken;
        entry.pred_target = pred_taken ? br_target : resp_pc + 32'd4;
    end

    assign dec_fire = dec_valid && dec_ready;

    fetch_queue #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fetch_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redir_valid),
        .push      (resp_keep),
        .push_data (entry),
        .pop       (dec_fire),
        .head      (q_head),
        .count     (q_count)
    );

    assign dec_valid       = (q_count != '0);
    assign dec_instr       = q_head.instr;
    assign dec_pc          = q_head.pc;
    assign dec_pred_taken  = q_head.pred_taken;
    assign dec_pred_target = q_head.pred_target;

    // drop_cnt counts down the wrong-path words still in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            drop_cnt <= '0;
            running  <= 1'b0;
        end else begin
            running <= 1'b1;
            if (redir_valid) begin
                fetch_pc <= {redir_pc[31:2], 2'b00};
                drop_cnt <= out_cnt - CW'(imem_resp_valid);
            end else if (take) begin
                fetch_pc <= br_target;
                drop_cnt <= out_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_resp_valid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen with an in-order, fixed-latency instruction memory model.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_pred_taken;
    logic [31:0] dec_pred_target;

    always #5 clk = ~clk;

    fetch_pc_gen #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redir_valid     (redir_valid),
        .redir_pc        (redir_pc),
        .dec_valid       (dec_valid),
        .dec_ready       (dec_ready),
        .dec_instr       (dec_instr),
        .dec_pc          (dec_pc),
        .dec_pred_taken  (dec_pred_taken),
        .dec_pred_target (dec_pred_target)
    );

    typedef struct {
        logic [31:0] addr;
        int          t;
    } pend_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } dec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] redir;
        logic [31:0] pc;
        int          lat;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic [31:0] exp_next;
    } vec_t;

    pend_t       pend[$];
    logic [31:0] req_log[$];
    int          req_cyc[$];
    logic [31:0] resp_log[$];
    dec_t        dec_log[$];
    logic [31:0] mem_over [logic [31:0]];
    int          cyc = 0;
    int          lat = 1;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] instr_at(logic [31:0] a);
        if (mem_over.exists(a)) return mem_over[a];
        return 32'h0000_0013;
    endfunction

    function automatic logic [31:0] rq(int i);
        if (i < req_log.size()) return req_log[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic dec_t dq(int i);
        dec_t d;
        d = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'bx, 32'hDEAD_BEEF};
        if (i < dec_log.size()) d = dec_log[i];
        return d;
    endfunction

    // Memory model and monitors sample the pre-edge values at the rising edge.
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (imem_resp_valid && pend.size() > 0) begin
                resp_log.push_back(pend[0].addr);
                void'(pend.pop_front());
            end
            if (imem_req_valid && imem_req_ready) begin
                pend.push_back('{imem_req_addr, cyc});
                req_log.push_back(imem_req_addr);
                req_cyc.push_back(cyc);
            end
            if (dec_valid && dec_ready)
                dec_log.push_back('{dec_instr, dec_pc, dec_pred_taken, dec_pred_target});
        end
    end

    always @(negedge clk) begin
        if (rst_n && pend.size() > 0 && cyc >= pend[0].t + lat - 1) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_at(pend[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] pc);
        redir_valid = 1'b1;
        redir_pc    = pc;
        step();
        redir_valid = 1'b0;
        dec_log.delete();
        req_log.delete();
        req_cyc.delete();
    endtask

    task automatic wait_dec(input int n);
        for (int k = 0; k < 80 && dec_log.size() < n; k++) step();
        chk("dec entries arrived", 32'(dec_log.size() >= n), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int   nd;
        logic found;
        dec_t d;

        vecs[0] = '{32'h0000_0863, 32'h0000_0100, 32'h0000_0100, 1, 1'b0, 32'h0000_0104, 32'h0000_0104};
        vecs[1] = '{32'hFE00_0CE3, 32'h0000_0100, 32'h0000_0100, 3, 1'b1, 32'h0000_00F8, 32'h0000_00F8};
        vecs[2] = '{32'hFE00_1EE3, 32'h0000_0000, 32'h0000_0000, 2, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
        vecs[3] = '{32'hFF5F_F06F, 32'h0000_0200, 32'h0000_0200, 1, 1'b0, 32'h0000_0204, 32'h0000_0204};
        vecs[4] = '{32'hFFF0_0013, 32'h0000_0300, 32'h0000_0300, 1, 1'b0, 32'h0000_0304, 32'h0000_0304};
        vecs[5] = '{32'hFE00_0CE3, 32'h0000_0403, 32'h0000_0400, 2, 1'b1, 32'h0000_03F8, 32'h0000_03F8};

        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        dec_ready      = 1'b1;
        redir_valid    = 1'b0;
        redir_pc       = 32'h0;
        repeat (3) step();

        chk("reset req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset req_addr", imem_req_addr, 32'h0);
        chk("reset dec_valid", 32'(dec_valid), 32'd0);
        chk("reset dec_instr", dec_instr, 32'h0);
        chk("reset dec_pc", dec_pc, 32'h0);
        chk("reset pred_taken", 32'(dec_pred_taken), 32'd0);
        chk("reset pred_target", dec_pred_target, 32'h0);

        rst_n = 1'b1;
        step();
        chk("first req_valid", 32'(imem_req_valid), 32'd1);
        chk("first req_addr", imem_req_addr, 32'h0);
        repeat (6) step();
        chk("startup req0", rq(0), 32'h0);
        chk("startup req1", rq(1), 32'h4);
        chk("startup req2", rq(2), 32'h8);
        chk("startup back-to-back", 32'(req_cyc.size() >= 3 && req_cyc[2] - req_cyc[0] == 2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            d = dq(i);
            chk($sformatf("startup dec_pc %0d", i), d.pc, 32'(4 * i));
            chk($sformatf("startup pred %0d", i), 32'(d.taken), 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            lat = vecs[i].lat;
            mem_over[vecs[i].pc] = vecs[i].instr;
            step();
            redirect(vecs[i].redir);
            chk($sformatf("vec%0d redirect req_addr", i), imem_req_addr, vecs[i].pc);
            chk($sformatf("vec%0d redirect dec_valid", i), 32'(dec_valid), 32'd0);
            wait_dec(2);
            d = dq(0);
            chk($sformatf("vec%0d pc", i), d.pc, vecs[i].pc);
            chk($sformatf("vec%0d instr", i), d.instr, vecs[i].instr);
            chk($sformatf("vec%0d pred_taken", i), 32'(d.taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d pred_target", i), d.target, vecs[i].exp_target);
            chk($sformatf("vec%0d next pc", i), dq(1).pc, vecs[i].exp_next);
            mem_over.delete(vecs[i].pc);
        end

        lat = 1;
        step();
        redirect(32'hFFFF_FFFC);
        repeat (3) step();
        chk("wrap req0", rq(0), 32'hFFFF_FFFC);
        chk("wrap req1", rq(1), 32'h0000_0000);

        dec_ready = 1'b0;
        step();
        redirect(32'h0000_1000);
        repeat (12) step();
        chk("stall request count", 32'(req_log.size()), 32'd4);
        chk("stall last req", rq(3), 32'h0000_100C);
        chk("stall req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall dec_valid", 32'(dec_valid), 32'd1);
        chk("stall dec_pc", dec_pc, 32'h0000_1000);
        dec_ready = 1'b1;
        repeat (8) step();
        for (int i = 0; i < 5; i++)
            chk($sformatf("drain dec_pc %0d", i), dq(i).pc, 32'h0000_1000 + 32'(4 * i));

        lat = 3;
        redirect(32'h0000_3000);
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            step();
            if (imem_resp_valid && pend.size() == 3) found = 1'b1;
        end
        chk("redirect setup found", 32'(found), 32'd1);
        nd = resp_log.size();
        redirect(32'h0000_2000);
        chk("redirect flush dec_valid", 32'(dec_valid), 32'd0);
        wait_dec(1);
        chk("redirect first dec_pc", dq(0).pc, 32'h0000_2000);
        begin
            int dropped = 0;
            for (int i = nd; i < resp_log.size() && resp_log[i] != 32'h0000_2000; i++) dropped++;
            chk("redirect dropped count", 32'(dropped), 32'd3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
